// File: rtl/luna_l0_pkg.sv
// rtl/luna_l0_pkg.sv - shared widths, thresholds, frame type and quantizer for layer-0 input path
package luna_l0_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int QBITS      = 2;
  localparam int NUM_FEAT   = 3;
  localparam int FRAME_W    = NUM_FEAT * QBITS;
  localparam int NUM_THRESH = (1 << QBITS) - 1;
  localparam int IDX_W      = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  // Threshold t sits at [t*SAMPLE_W +: SAMPLE_W], ascending from the LSB.
  localparam logic [NUM_THRESH*SAMPLE_W-1:0] THRESH = {16'sd512, 16'sd0, -16'sd512};

  typedef logic [FRAME_W-1:0] l0_frame_t;
  typedef logic [QBITS-1:0]   l0_code_t;

  function automatic l0_code_t quantize(input logic signed [SAMPLE_W-1:0] s);
    l0_code_t c;
    c = '0;
    for (int t = 0; t < NUM_THRESH; t++) begin
      if (s >= $signed(THRESH[t*SAMPLE_W +: SAMPLE_W])) c = c + l0_code_t'(1);
    end
    return c;
  endfunction

endpackage

// File: rtl/l0_frame_fifo.sv
// rtl/l0_frame_fifo.sv - 2-entry frame FIFO with registered head output
module l0_frame_fifo #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Pushes while full are excluded by the producer holding its ready low.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop     = (count_q != 2'd0) && out_ready;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  assign full      = (count_q == 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

endmodule

// File: rtl/layer0_input_quantizer.sv
// rtl/layer0_input_quantizer.sv - sample quantizer and frame collector feeding layer-0 neurons
// Optional FRAME_CNT_EN adds a 16-bit popped-frame counter port.
module layer0_input_quantizer
  import luna_l0_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_first,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [FRAME_W-1:0]  m_data,
`ifdef FRAME_CNT_EN
  output logic [15:0]         frame_cnt,
`endif
  output logic                resync_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  l0_frame_t        slots_q, slots_d;
  logic             resync_err_q, resync_err_d;
  l0_frame_t        push_data;
  logic             push, accept, at_last, fifo_full;
  l0_code_t         code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      slots_q      <= '0;
      resync_err_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      slots_q      <= slots_d;
      resync_err_q <= resync_err_d;
    end
  end

  assign code    = quantize(s_data);
  assign at_last = (idx_q == LAST_IDX);
  assign s_ready = !(at_last && fifo_full);
  assign accept  = s_valid && s_ready;

  // A resync beat restarts the frame with all other slots cleared.
  always_comb begin
    idx_d        = idx_q;
    slots_d      = slots_q;
    resync_err_d = 1'b0;
    push         = 1'b0;
    push_data    = slots_q;
    if (accept) begin
      if (s_first && (idx_q != '0)) begin
        slots_d              = '0;
        slots_d[QBITS-1:0]   = code;
        idx_d                = IDX_W'(1);
        resync_err_d         = 1'b1;
      end else if (at_last) begin
        push_data[(NUM_FEAT-1)*QBITS +: QBITS] = code;
        push    = 1'b1;
        slots_d = '0;
        idx_d   = '0;
      end else begin
        slots_d[idx_q*QBITS +: QBITS] = code;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign resync_err = resync_err_q;

  l0_frame_fifo #(.W(FRAME_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push),
    .in_data   (push_data),
    .full      (fifo_full),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data)
  );

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (m_valid && m_ready) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// tb/tb_layer0_input_quantizer.sv - directed self-checking bench for layer0_input_quantizer
module tb_layer0_input_quantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_first;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  m_data;
  logic        resync_err;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer0_input_quantizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_first    (s_first),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .resync_err (resync_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic signed [15:0] d, input logic f);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    n = 0;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    step();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    m_ready = 1'b0;
    repeat (2) step();
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {26'd0, m_data}, 32'd0);
    check("rst_resync", {31'd0, resync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic frame: -600 -> 0, 100 -> 2, 700 -> 3
    m_ready = 1'b1;
    send_beat(-16'sd600, 1'b1);
    send_beat(16'sd100, 1'b0);
    check("basic_not_yet", {31'd0, m_valid}, 32'd0);
    send_beat(16'sd700, 1'b0);
    check("basic_valid", {31'd0, m_valid}, 32'd1);
    check("basic_data", {26'd0, m_data}, 32'b111000);
    step();
    check("basic_popped", {31'd0, m_valid}, 32'd0);

    // Threshold boundaries
    send_beat(16'sd512, 1'b1);
    send_beat(16'sd511, 1'b0);
    send_beat(16'sd0, 1'b0);
    check("bound_a", {26'd0, m_data}, 32'b101011);
    send_beat(-16'sd1, 1'b1);
    send_beat(-16'sd512, 1'b0);
    send_beat(-16'sd513, 1'b0);
    check("bound_b", {26'd0, m_data}, 32'b000101);
    step();

    // Backpressure: two frames queued, third blocks at its last beat
    m_ready = 1'b0;
    send_beat(16'sd700, 1'b1);
    send_beat(16'sd700, 1'b0);
    send_beat(16'sd700, 1'b0);
    send_beat(-16'sd600, 1'b1);
    send_beat(-16'sd600, 1'b0);
    send_beat(16'sd700, 1'b0);
    send_beat(16'sd100, 1'b1);
    send_beat(-16'sd100, 1'b0);
    check("stall_s_ready", {31'd0, s_ready}, 32'd0);
    check("stall_head", {26'd0, m_data}, 32'b111111);
    s_valid = 1'b1;
    s_data  = -16'sd600;
    step();
    step();
    check("stall_hold", {26'd0, m_data}, 32'b111111);
    check("stall_still_blocked", {31'd0, s_ready}, 32'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("drain_f2", {26'd0, m_data}, 32'b110000);
    check("drain_ready", {31'd0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
    check("drain_f2_held", {26'd0, m_data}, 32'b110000);
    m_ready = 1'b1;
    step();
    check("drain_f3_valid", {31'd0, m_valid}, 32'd1);
    check("drain_f3", {26'd0, m_data}, 32'b000110);
    step();
    check("drain_empty", {31'd0, m_valid}, 32'd0);

    // Resync on second beat
    send_beat(16'sd700, 1'b1);
    send_beat(-16'sd600, 1'b1);
    check("resync_pulse", {31'd0, resync_err}, 32'd1);
    check("resync_no_frame", {31'd0, m_valid}, 32'd0);
    step();
    check("resync_one_cycle", {31'd0, resync_err}, 32'd0);
    send_beat(-16'sd1, 1'b0);
    send_beat(16'sd0, 1'b0);
    check("resync_frame_valid", {31'd0, m_valid}, 32'd1);
    check("resync_frame", {26'd0, m_data}, 32'b100100);
    step();

    // Asynchronous reset mid-frame with one frame queued
    m_ready = 1'b0;
    send_beat(16'sd700, 1'b1);
    send_beat(16'sd700, 1'b0);
    send_beat(16'sd700, 1'b0);
    send_beat(16'sd100, 1'b1);
    check("prereset_valid", {31'd0, m_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", {26'd0, m_data}, 32'd0);
    check("reset_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    send_beat(-16'sd1, 1'b0);
    send_beat(-16'sd512, 1'b0);
    send_beat(-16'sd513, 1'b0);
    check("post_reset_valid", {31'd0, m_valid}, 32'd1);
    check("post_reset_frame", {26'd0, m_data}, 32'b000101);
    step();
`ifdef FRAME_CNT_EN
    check("frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
